bus_arbiter: RTL and testbench

- Two-master arbiter for the simple shared bus.
- Decides each cycle which master (M0 or M1) drives the shared address, write-data and control muxes that feed the slave address decoder and slaves.
- Grants are registered. Arbitration is round-robin, and a hold limit stops one master from starving the other.
- Sits between the master request lines and the bus mux select.

---
 rtl/bus_pkg.sv | 18 +
 rtl/arb_hold_cnt.sv | 38 +++
 rtl/bus_arbiter.sv | 107 ++++++++++
 tb/tb_bus_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types and constants for the two-master bus arbiter.
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  // Grant state owned by master id m.
  function automatic state_e gnt_state(input logic m);
    return m ? ST_GNT1 : ST_GNT0;
  endfunction

endpackage

// File: rtl/arb_hold_cnt.sv
// Saturating hold counter for the arbiter; tc_o flags the last allowed contested cycle.
module arb_hold_cnt #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] TcVal  = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
  localparam bit               HoldEn = (MAX_HOLD != 0);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = HoldEn && (cnt_q == TcVal);

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with registered grants and hold-limit preemption.
module bus_arbiter #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic m0_req,
  input  logic m1_req,
  output logic m0_grant,
  output logic m1_grant,
  output logic m_sel,
  output logic bus_busy,
  output logic preempt
);

  import bus_pkg::*;

  state_e state_q, state_d;
  logic   last_q, last_d;
  logic   m_sel_q, m_sel_d;
  logic   preempt_q, preempt_d;
  logic   owner_req, other_req;
  logic   hold_tc, cnt_clr, entering;

  always_comb begin
    state_d   = state_q;
    preempt_d = 1'b0;
    owner_req = 1'b0;
    other_req = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (m0_req && m1_req) begin
          state_d = gnt_state(~last_q);
        end else if (m0_req) begin
          state_d = ST_GNT0;
        end else if (m1_req) begin
          state_d = ST_GNT1;
        end
      end
      ST_GNT0: begin
        owner_req = m0_req;
        other_req = m1_req;
        if (!m0_req) begin
          state_d = m1_req ? ST_GNT1 : ST_IDLE;
        end else if (m1_req && hold_tc) begin
          state_d   = ST_GNT1;
          preempt_d = 1'b1;
        end
      end
      ST_GNT1: begin
        owner_req = m1_req;
        other_req = m0_req;
        if (!m1_req) begin
          state_d = m0_req ? ST_GNT0 : ST_IDLE;
        end else if (m0_req && hold_tc) begin
          state_d   = ST_GNT0;
          preempt_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    entering = (state_d != state_q) && (state_d != ST_IDLE);
    last_d   = last_q;
    m_sel_d  = m_sel_q;
    if (entering) begin
      last_d  = (state_d == ST_GNT1) ? M1 : M0;
      m_sel_d = last_d;
    end

    // Counter only runs while the owner keeps the bus against a waiting requester.
    cnt_clr = entering || (state_d == ST_IDLE) || !other_req || !owner_req;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      last_q    <= M1;
      m_sel_q   <= M0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      m_sel_q   <= m_sel_d;
      preempt_q <= preempt_d;
    end
  end

  arb_hold_cnt #(
    .MAX_HOLD (MAX_HOLD),
    .CNT_W    (CNT_W)
  ) u_hold_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (cnt_clr),
    .en_i  (other_req),
    .tc_o  (hold_tc)
  );

  assign m0_grant = (state_q == ST_GNT0);
  assign m1_grant = (state_q == ST_GNT1);
  assign bus_busy = m0_grant | m1_grant;
  assign m_sel    = m_sel_q;
  assign preempt  = preempt_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed vector table, corner sequences, random model run.
module tb_bus_arbiter;

  localparam int MaxHold = 4;

  logic clk = 1'b0;
  logic reset;
  logic m0_req, m1_req;
  logic m0_grant, m1_grant, m_sel, bus_busy, preempt;

  always #5 clk = ~clk;

  bus_arbiter #(
    .MAX_HOLD (MaxHold),
    .CNT_W    (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .m0_req   (m0_req),
    .m1_req   (m1_req),
    .m0_grant (m0_grant),
    .m1_grant (m1_grant),
    .m_sel    (m_sel),
    .bus_busy (bus_busy),
    .preempt  (preempt)
  );

  typedef struct packed {
    logic g0;
    logic g1;
    logic sel;
    logic busy;
    logic pre;
  } exp_t;

  typedef struct {
    logic r0;
    logic r1;
    exp_t e;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state for the random phase.
  int   m_own;
  int   m_hc;
  logic m_last;
  logic m_msel;

  function automatic exp_t mk(input logic g0, input logic g1, input logic sel, input logic pre);
    exp_t e;
    e.g0   = g0;
    e.g1   = g1;
    e.sel  = sel;
    e.busy = g0 | g1;
    e.pre  = pre;
    return e;
  endfunction

  task automatic add(input logic r0, input logic r1, input logic g0, input logic g1,
                     input logic sel, input logic pre);
    vec_t v;
    v.r0 = r0;
    v.r1 = r1;
    v.e  = mk(g0, g1, sel, pre);
    tbl.push_back(v);
  endtask

  task automatic check_out(input string name);
    exp_t e;
    exp_t a;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = exp_q.pop_front();
    a = {m0_grant, m1_grant, m_sel, bus_busy, preempt};
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got {g0,g1,sel,busy,pre}=%05b required %05b", name, a, e);
    end
    n_cmp++;
    if (m0_grant && m1_grant) begin
      n_bad++;
      $display("FAIL %s_onehot: got both grants high required at most one", name);
    end
  endtask

  task automatic expect_edge(input exp_t e, input string name);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check_out(name);
  endtask

  task automatic drive(input logic r0, input logic r1, input exp_t e, input string name);
    @(negedge clk);
    m0_req = r0;
    m1_req = r1;
    expect_edge(e, name);
  endtask

  task automatic model_reset();
    m_own  = 0;
    m_hc   = 0;
    m_last = 1'b1;
    m_msel = 1'b0;
  endtask

  task automatic model_step(input logic r0, input logic r1, output exp_t e);
    int   nxt;
    logic mine, oth, pre;
    pre = 1'b0;
    nxt = m_own;
    if (m_own == 0) begin
      if (r0 && r1) nxt = m_last ? 1 : 2;
      else if (r0)  nxt = 1;
      else if (r1)  nxt = 2;
      m_hc = 0;
    end else begin
      mine = (m_own == 1) ? r0 : r1;
      oth  = (m_own == 1) ? r1 : r0;
      if (!mine) begin
        nxt = oth ? 3 - m_own : 0;
      end else if (oth && m_hc == MaxHold - 1) begin
        nxt = 3 - m_own;
        pre = 1'b1;
      end
      if (nxt == m_own && oth) m_hc = (m_hc < 255) ? m_hc + 1 : m_hc;
      else m_hc = 0;
    end
    if (nxt != m_own && nxt != 0) begin
      m_last = (nxt == 2);
      m_msel = (nxt == 2);
      m_hc   = 0;
    end
    m_own = nxt;
    e = mk(m_own == 1, m_own == 2, m_msel, pre);
  endtask

  initial begin
    exp_t e;
    logic r0, r1, pg0, pg1;
    int   w0, w1;

    reset  = 1'b1;
    m0_req = 1'b0;
    m1_req = 1'b0;
    #1;
    exp_q.push_back(mk(0, 0, 0, 0));
    check_out("reset_state");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // r0 r1 | g0 g1 sel pre
    add(0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 0, 0);
    add(1, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 1, 1, 0);  // tie after M0 owned: M1 wins
    add(1, 1, 0, 1, 1, 0);
    add(1, 1, 0, 1, 1, 0);
    add(1, 1, 0, 1, 1, 0);
    add(1, 1, 1, 0, 0, 1);  // hold expiry after 4 contested cycles
    add(1, 1, 1, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0);
    add(1, 1, 0, 1, 1, 1);
    add(1, 0, 1, 0, 0, 0);  // same-edge handover
    add(1, 1, 1, 0, 0, 0);
    add(1, 0, 1, 0, 0, 0);  // contest withdrawn: counter restarts
    add(1, 1, 1, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0);
    add(1, 1, 0, 1, 1, 1);
    add(0, 1, 0, 1, 1, 0);
    add(1, 1, 0, 1, 1, 0);  // loser re-asserts: waits full hold
    add(1, 1, 0, 1, 1, 0);
    add(1, 1, 0, 1, 1, 0);
    add(1, 1, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1, 1, 0);
    add(0, 0, 0, 0, 1, 0);  // m_sel holds in idle
    add(1, 0, 1, 0, 0, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].r0, tbl[i].r1, tbl[i].e, $sformatf("vec%0d", i));
    end

    // Uncontested M1 keeps the bus indefinitely.
    for (int i = 0; i < 50; i++) begin
      drive(1'b0, 1'b1, mk(0, 1, 1, 0), $sformatf("m1_solo%0d", i));
    end

    // Mid-cycle asynchronous reset while M1 owns the bus.
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    exp_q.push_back(mk(0, 0, 0, 0));
    check_out("async_reset");
    @(negedge clk);
    m0_req = 1'b1;
    m1_req = 1'b1;
    reset  = 1'b0;
    expect_edge(mk(1, 0, 0, 0), "post_reset_tie");

    // Random streams against the reference model.
    @(negedge clk);
    reset  = 1'b1;
    m0_req = 1'b0;
    m1_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    r0  = 1'b0;
    r1  = 1'b0;
    pg0 = 1'b0;
    pg1 = 1'b0;
    w0  = 0;
    w1  = 0;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(3) == 0) r0 = ~r0;
      if ($urandom_range(3) == 0) r1 = ~r1;
      model_step(r0, r1, e);
      drive(r0, r1, e, "random");
      n_cmp++;
      if ((m0_grant && !pg0 && !r0) || (m1_grant && !pg1 && !r1)) begin
        n_bad++;
        $display("FAIL grant_no_req: got grant rise g0=%b g1=%b with req r0=%b r1=%b",
                 m0_grant, m1_grant, r0, r1);
      end
      w0 = (r0 && !m0_grant) ? w0 + 1 : 0;
      w1 = (r1 && !m1_grant) ? w1 + 1 : 0;
      n_cmp++;
      if (w0 > MaxHold + 1 || w1 > MaxHold + 1) begin
        n_bad++;
        $display("FAIL starvation: got wait w0=%0d w1=%0d required <= %0d", w0, w1, MaxHold + 1);
      end
      pg0 = m0_grant;
      pg1 = m1_grant;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
